pwm_led_driver: RTL and testbench

PWM_LED_DRIVER -- requirements
Module: pwm_led_driver

---
 rtl/pwm_led_driver.sv | 135 +++++++++++++
 tb/tb_pwm_led_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_led_driver.sv
// ============================================================================
//  Module      : pwm_led_driver
//  Description : Four-channel LED PWM driver. A shared prescaler divides the
//                system clock by PRESCALE, and a shared 8-bit counter cnt runs
//                0..254, so each PWM period lasts 255*PRESCALE clocks. Duty
//                bytes from pwm_cfg are captured into shadow registers only at
//                the start of each period (the load cycle). This means a
//                register write can never cut a pulse short or add a runt
//                pulse.
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous reset, active low (0 = reset)
//                pwm_cfg      - packed duty word, byte i = duty of channel i
//                pwm          - registered PWM outputs, one bit per channel
//                period_start - one-clock pulse on the first output cycle of
//                               every period
//  Parameters  : PRESCALE     - system clocks per count step (1..65535)
//  Macros      : PWM_LED_DRIVER_GAMMA_EN - when defined, each duty byte is
//                mapped through eff(d) = (d*d + 255) >> 8 (a squared
//                perceptual curve). When undefined, eff(d) = d.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_led_driver #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pwm_cfg,
    output logic [3:0]  pwm,
    output logic        period_start
);

    localparam logic [7:0] c_cnt_last = 8'd254;

    // Duty mapping applied on the way into the shadow registers.
    function automatic logic [7:0] eff(input logic [7:0] d);
`ifdef PWM_LED_DRIVER_GAMMA_EN
        logic [15:0] sq;
        // 255*255 + 255 = 65280, so the sum fits in 16 bits.
        sq = ({8'd0, d} * {8'd0, d}) + 16'd255;
        return sq[15:8];
`else
        return d;
`endif
    endfunction

    logic       w_tick;
    logic       w_presc_zero;
    logic       w_load;
    logic [7:0] r_cnt;
    logic [7:0] r_shadow [4];
    logic [7:0] w_duty   [4];
    logic [3:0] r_pwm;
    logic       r_period_start;

    // ------------------------------------------------------------------
    // Prescaler. When PRESCALE is 1, no register is built and every cycle
    // is a tick.
    // ------------------------------------------------------------------
    generate
        if (PRESCALE == 1) begin : g_presc_none
            assign w_tick       = 1'b1;
            assign w_presc_zero = 1'b1;
        end else begin : g_presc
            localparam logic [15:0] c_presc_max = 16'(PRESCALE - 1);
            logic [15:0] r_prescaler;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_prescaler <= '0;
                end else if (r_prescaler == c_presc_max) begin
                    r_prescaler <= '0;
                end else begin
                    r_prescaler <= r_prescaler + 16'd1;
                end
            end

            assign w_tick       = (r_prescaler == c_presc_max);
            assign w_presc_zero = (r_prescaler == 16'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Period counter, 0..254.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= (r_cnt == c_cnt_last) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    // The first cycle of every period. Reset leaves both counters at zero,
    // so the first cycle after reset release is also a load cycle.
    assign w_load = w_presc_zero && (r_cnt == 8'd0);

    // The duty used in the load cycle bypasses the shadow register. This
    // lets the new value take effect in that cycle's output, so the new
    // period does not begin with a stale bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_duty
            assign w_duty[gi] = w_load ? eff(pwm_cfg[8*gi +: 8]) : r_shadow[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shadow registers and outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load) begin
                    r_shadow[i] <= w_duty[i];
                end
                // cnt never reaches 255, so a duty of 255 keeps the output high.
                r_pwm[i] <= (r_cnt < w_duty[i]);
            end
            r_period_start <= w_load;
        end
    end

    assign pwm          = r_pwm;
    assign period_start = r_period_start;

endmodule

`default_nettype wire

// File: tb/tb_pwm_led_driver.sv
// ============================================================================
//  Module      : tb_pwm_led_driver
//  Description : Self-checking bench for pwm_led_driver. It uses two
//                instances, PRESCALE=2 and PRESCALE=1. An arithmetic
//                reference model tracks the position inside the period and
//                checks every cycle. Table vectors and hand-written sequences
//                measure high-clock counts per period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_led_driver;

    logic        clk = 1'b0;
    logic        reset2 = 1'b0;
    logic        reset1 = 1'b0;
    logic [31:0] cfg2 = '0;
    logic [31:0] cfg1 = '0;
    logic [3:0]  pwm2, pwm1;
    logic        ps2, ps1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_led_driver #(.PRESCALE(2)) u_dut2 (
        .clk(clk), .reset(reset2), .pwm_cfg(cfg2), .pwm(pwm2), .period_start(ps2)
    );
    pwm_led_driver #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset1), .pwm_cfg(cfg1), .pwm(pwm1), .period_start(ps1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff(input int d);
`ifdef PWM_LED_DRIVER_GAMMA_EN
        return (d * d + 255) / 256;
`else
        return d;
`endif
    endfunction

    int         m_k    [2];     // clocks elapsed since reset release
    int         m_duty [2][4];
    logic [3:0] m_pwm  [2];
    logic       m_ps   [2];

    task automatic model_step(input int idx, input int p_scale,
                              input logic r, input logic [31:0] cfg);
        int p;
        if (!r) begin
            m_k[idx] = 0;
            for (int i = 0; i < 4; i++) m_duty[idx][i] = 0;
            m_pwm[idx] = '0;
            m_ps[idx]  = 1'b0;
        end else begin
            p = m_k[idx] % (255 * p_scale);
            if (p == 0)
                for (int i = 0; i < 4; i++) m_duty[idx][i] = eff(int'(cfg[8*i +: 8]));
            for (int i = 0; i < 4; i++) m_pwm[idx][i] = ((p / p_scale) < m_duty[idx][i]);
            m_ps[idx] = (p == 0);
            m_k[idx]  = m_k[idx] + 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 2, reset2, cfg2);
        model_step(1, 1, reset1, cfg1);
        #1;
        chk("sb_p2_pwm", int'(pwm2), int'(m_pwm[0]));
        chk("sb_p2_ps",  int'(ps2),  int'(m_ps[0]));
        chk("sb_p1_pwm", int'(pwm1), int'(m_pwm[1]));
        chk("sb_p1_ps",  int'(ps1),  int'(m_ps[1]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hi[4];
    int psn;
    int rises0;
    int coin0;

    // Samples n output cycles and accumulates per-channel high counts,
    // period_start pulses, ch0 rising edges and ch0-high-with-period_start.
    task automatic run_period(input int sel, input int n, input int chg_at,
                              input logic [31:0] chg_cfg);
        logic [3:0] cur;
        logic       cps;
        logic       prev0;
        prev0 = 1'b0;
        psn = 0; rises0 = 0; coin0 = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < n; i++) begin
            step();
            cur = (sel == 0) ? pwm2 : pwm1;
            cps = (sel == 0) ? ps2 : ps1;
            for (int c = 0; c < 4; c++) if (cur[c]) hi[c]++;
            if (cps) psn++;
            if (cps && cur[0]) coin0++;
            if (cur[0] && !prev0) rises0++;
            prev0 = cur[0];
            if (i == chg_at) begin
                if (sel == 0) cfg2 = chg_cfg;
                else          cfg1 = chg_cfg;
            end
        end
    endtask

    typedef struct {
        logic [31:0] cfg;
        int          hi[4];
    } vec_t;

    vec_t tbl[4];

    initial begin
        // One-period high-clock counts at PRESCALE=2 (510 clocks/period).
        tbl[0].cfg = 32'hFF80_0100;
        tbl[1].cfg = 32'h40C0_1080;
        tbl[2].cfg = 32'h0000_0000;
        tbl[3].cfg = 32'hFFFF_FFFF;
`ifdef PWM_LED_DRIVER_GAMMA_EN
        tbl[0].hi = '{0, 2, 128, 510};
        tbl[1].hi = '{128, 2, 288, 32};
`else
        tbl[0].hi = '{0, 2, 256, 510};
        tbl[1].hi = '{256, 32, 384, 128};
`endif
        tbl[2].hi = '{0, 0, 0, 0};
        tbl[3].hi = '{510, 510, 510, 510};

        // Reset held for 5 clocks with all duties at full scale.
        reset2 = 1'b0; reset1 = 1'b0;
        cfg2 = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_pwm", int'(pwm2), 0);
            chk("rst_ps",  int'(ps2),  0);
        end
        reset2 = 1'b1;
        step();
        chk("rel_pwm", int'(pwm2), 4'hF);
        chk("rel_ps",  int'(ps2),  1);

        // Table vectors: each starts from reset so period alignment is known.
        for (int t = 0; t < 4; t++) begin
            reset2 = 1'b0;
            cfg2 = tbl[t].cfg;
            step();
            reset2 = 1'b1;
            run_period(0, 510, -1, 32'h0);
            for (int c = 0; c < 4; c++)
                chk($sformatf("tbl%0d_hi_ch%0d", t, c), hi[c], tbl[t].hi[c]);
            chk($sformatf("tbl%0d_psn", t), psn, 1);
            step();
            chk($sformatf("tbl%0d_next_ps", t), int'(ps2), 1);
        end

        // A mid-period duty change takes effect only from the next period.
        reset2 = 1'b0;
        cfg2 = 32'h0000_0040;
        step();
        reset2 = 1'b1;
        run_period(0, 510, 100, 32'h0000_00C0);
`ifdef PWM_LED_DRIVER_GAMMA_EN
        chk("mid_cur_hi", hi[0], 32);
`else
        chk("mid_cur_hi", hi[0], 128);
`endif
        chk("mid_cur_rises", rises0, 1);
        run_period(0, 510, -1, 32'h0);
`ifdef PWM_LED_DRIVER_GAMMA_EN
        chk("mid_next_hi", hi[0], 288);
`else
        chk("mid_next_hi", hi[0], 384);
`endif
        chk("mid_next_rises", rises0, 1);

        // Reset pulse in the middle of a period.
        reset2 = 1'b0;
        cfg2 = 32'h0000_0080;
        step();
        reset2 = 1'b1;
        run_period(0, 300, -1, 32'h0);
        reset2 = 1'b0;
        step();
        chk("midrst_pwm", int'(pwm2), 0);
        chk("midrst_ps",  int'(ps2),  0);
        reset2 = 1'b1;
        step();
        chk("midrst_fresh_ps",  int'(ps2), 1);
        chk("midrst_fresh_ch0", int'(pwm2[0]), 1);

        // PRESCALE=1: duty 0x80, then 0xFF.
        reset1 = 1'b0;
        cfg1 = 32'h0000_0080;
        step();
        reset1 = 1'b1;
        run_period(1, 255, -1, 32'h0);
`ifdef PWM_LED_DRIVER_GAMMA_EN
        chk("p1_80_hi", hi[0], 64);
`else
        chk("p1_80_hi", hi[0], 128);
`endif
        cfg1 = 32'h0000_00FF;
        run_period(1, 255, -1, 32'h0);
        chk("p1_ff_hi", hi[0], 255);

        // PRESCALE=1, duty 1: a single high clock that coincides with period_start.
        reset1 = 1'b0;
        cfg1 = 32'h0000_0001;
        step();
        reset1 = 1'b1;
        run_period(1, 255, -1, 32'h0);
        chk("p1_01_hi",   hi[0], 1);
        chk("p1_01_psn",  psn,   1);
        chk("p1_01_coin", coin0, 1);

        // Random duty writes and occasional resets, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 39) == 0) cfg2 = $urandom;
            if ($urandom_range(0, 29) == 0) cfg1 = $urandom;
            if ($urandom_range(0, 9) == 0)  cfg1[7:0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            reset2 = ($urandom_range(0, 599) != 0);
            reset1 = ($urandom_range(0, 399) != 0);
        end
        reset2 = 1'b1;
        reset1 = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
